writeback_queue: RTL and testbench
==================================

WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 SHALL clock and reset: one clock; reset is asynchronous and active-low.
REQ-002 SHALL port clk  in  1  sole clock; all state on rising edge.
REQ-003 SHALL port rst  in  1  asynchronous active-low reset.
REQ-004 SHALL ports alu_valid in 1, alu_ready out 1, alu_rd in 5, alu_data in 64: ALU result channel.
REQ-005 SHALL ports lsu_valid in 1, lsu_ready out 1, lsu_rd in 5, lsu_data in 64: load-unit result channel.
REQ-006 SHALL port wr_stall  in  1  register-file write port unavailable this cycle.
REQ-007 SHALL ports we out 1, wr_addr out 5, wr_data out 64: register-file write port.
REQ-008 SHALL ports fwd_addr_0/fwd_addr_1 in 5, fwd_hit_0/fwd_hit_1 out 1, fwd_data_0/fwd_data_1 out 64: forwarding lookup.

Function
REQ-009 SHALL hold a 4-entry FIFO of {rd[4:0], data[63:0]}; 2-bit read/write pointers wrap 3->0; 3-bit count 0..4.
REQ-010 SHALL accept at most one result per cycle; transfer occurs on valid&ready at a rising edge.
REQ-011 SHALL arbitrate round-robin: priority bit initially ALU; on a cycle where both valid and a transfer occurs, winner loses priority next cycle; lone requester granted regardless of priority bit.
REQ-012 SHALL drive ready high only for the granted source and only when count<4; a same-cycle pop does not free space for a push (full => both ready low).
REQ-013 SHALL accept rd=0 transfers (ready per REQ-012) but discard them without pushing.
REQ-014 SHALL drive we=1 combinationally when count>0 and wr_stall=0, with wr_addr/wr_data from head entry; otherwise we=0, wr_addr=0, wr_data=0.
REQ-015 SHALL pop the head at the rising edge where we=1.
REQ-016 SHALL give one-cycle latency: result accepted at edge N into empty FIFO -> we=1 in cycle after N, register file written at edge N+1 (if no stall).
REQ-017 SHALL preserve acceptance order on the write port; simultaneous push and pop update count by 0.
REQ-018 SHALL hold all FIFO state while wr_stall=1; accepts continue until full.

Reset
REQ-019 SHALL on rst low, immediately and asynchronously clear count, both pointers, priority bit (ALU); we, wr_addr, wr_data, alu_ready, lsu_ready, fwd_hit_* and fwd_data_* read 0.
REQ-020 SHALL discard all queued entries when reset asserts mid-operation; no write issues after release until a new accept.
REQ-021 SHALL resume accepting on the first rising edge after rst returns high.

Configuration
REQ-022 SHALL compile forwarding only when macro WRITEBACK_QUEUE_FWD_EN is defined.
REQ-023 SHALL with WRITEBACK_QUEUE_FWD_EN: fwd_hit_k=1 iff fwd_addr_k!=0 and a valid entry has matching rd; fwd_data_k = data of newest matching entry; combinational, independent of wr_stall.
REQ-024 SHALL without WRITEBACK_QUEUE_FWD_EN: ports exist, fwd_hit_k=0, fwd_data_k=0 constantly.

Verification
REQ-025 SHALL cover: ALU valid rd=5 data=0x1234, FIFO empty, no stall -> we=1 wr_addr=5 wr_data=0x1234 next cycle, we=0 after.
REQ-026 SHALL cover: both valid every cycle, rd ALU=1 LSU=2, stall off -> grants alternate ALU,LSU,ALU,...; write sequence 1,2,1,2.
REQ-027 SHALL cover: wr_stall=1, 5 ALU pushes rd=1..5 -> ready low after 4th; release stall -> writes 1,2,3,4 on consecutive cycles, then rd=5 accepted.
REQ-028 SHALL cover: ALU rd=0 data=0xFF -> ready=1, no we pulse, count stays 0.
REQ-029 SHALL cover (FWD_EN): stall on, push rd=7 0xA then rd=7 0xB, fwd_addr_0=7 -> hit=1 data=0xB; fwd_addr_1=0 -> hit=0.
REQ-030 SHALL cover: 3 entries queued, rst low mid-cycle -> we=0 and readies 0 immediately; after release no writes until new accept.

Source files
------------

// File: rtl/writeback_queue.sv
// Writeback queue: merges ALU and load-unit results into one register-file write port.
// Optional forwarding lookup is compiled only when WRITEBACK_QUEUE_FWD_EN is defined.
module writeback_queue (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [63:0] alu_data,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic [4:0]  lsu_rd,
  input  logic [63:0] lsu_data,
  input  logic        wr_stall,
  output logic        we,
  output logic [4:0]  wr_addr,
  output logic [63:0] wr_data,
  input  logic [4:0]  fwd_addr_0,
  input  logic [4:0]  fwd_addr_1,
  output logic        fwd_hit_0,
  output logic        fwd_hit_1,
  output logic [63:0] fwd_data_0,
  output logic [63:0] fwd_data_1
);

  logic [4:0]  q_rd   [4];
  logic [63:0] q_data [4];
  logic [1:0]  wr_ptr, rd_ptr;
  logic [2:0]  count;
  logic        prio_lsu;

  logic        grant_alu, grant_lsu, not_full;
  logic        accept, push, pop;
  logic [4:0]  in_rd;
  logic [63:0] in_data;

  // A lone requester wins regardless of the priority bit.
  assign grant_alu = alu_valid & (~lsu_valid | ~prio_lsu);
  assign grant_lsu = lsu_valid & ~grant_alu;
  assign not_full  = (count != 3'd4);

  // Readies are gated by rst so they drop the instant reset asserts.
  assign alu_ready = rst & grant_alu & not_full;
  assign lsu_ready = rst & grant_lsu & not_full;

  assign accept  = alu_ready | lsu_ready;
  assign in_rd   = grant_alu ? alu_rd : lsu_rd;
  assign in_data = grant_alu ? alu_data : lsu_data;
  assign push    = accept & (in_rd != 5'd0);

  assign we      = rst & (count != 3'd0) & ~wr_stall;
  assign pop     = we;
  assign wr_addr = we ? q_rd[rd_ptr]   : 5'd0;
  assign wr_data = we ? q_data[rd_ptr] : 64'd0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
      count    <= 3'd0;
      prio_lsu <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      count <= count + {2'd0, push} - {2'd0, pop};
      if (alu_valid && lsu_valid && accept) prio_lsu <= grant_alu;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[wr_ptr]   <= in_rd;
      q_data[wr_ptr] <= in_data;
    end
  end

`ifdef WRITEBACK_QUEUE_FWD_EN
  // Scan oldest to newest so the newest matching entry wins.
  always_comb begin
    logic [1:0] idx;
    fwd_hit_0  = 1'b0;
    fwd_hit_1  = 1'b0;
    fwd_data_0 = 64'd0;
    fwd_data_1 = 64'd0;
    idx        = 2'd0;
    for (int i = 0; i < 4; i++) begin
      idx = rd_ptr + 2'(i);
      if (3'(i) < count) begin
        if (fwd_addr_0 != 5'd0 && q_rd[idx] == fwd_addr_0) begin
          fwd_hit_0  = 1'b1;
          fwd_data_0 = q_data[idx];
        end
        if (fwd_addr_1 != 5'd0 && q_rd[idx] == fwd_addr_1) begin
          fwd_hit_1  = 1'b1;
          fwd_data_1 = q_data[idx];
        end
      end
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_addr_0, fwd_addr_1};
  assign fwd_hit_0  = 1'b0;
  assign fwd_hit_1  = 1'b0;
  assign fwd_data_0 = 64'd0;
  assign fwd_data_1 = 64'd0;
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Directed self-checking bench for writeback_queue with hand-computed expectations.
module tb_writeback_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, lsu_valid, wr_stall;
  logic        alu_ready, lsu_ready, we;
  logic [4:0]  alu_rd, lsu_rd, wr_addr, fwd_addr_0, fwd_addr_1;
  logic [63:0] alu_data, lsu_data, wr_data, fwd_data_0, fwd_data_1;
  logic        fwd_hit_0, fwd_hit_1;

  int n_cmp = 0;
  int n_err = 0;

  writeback_queue dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .wr_stall(wr_stall), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .fwd_addr_0(fwd_addr_0), .fwd_addr_1(fwd_addr_1),
    .fwd_hit_0(fwd_hit_0), .fwd_hit_1(fwd_hit_1),
    .fwd_data_0(fwd_data_0), .fwd_data_1(fwd_data_1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; alu_valid = 1'b1; lsu_valid = 1'b1; wr_stall = 1'b0;
    alu_rd = 5'd1; lsu_rd = 5'd2; alu_data = 64'd0; lsu_data = 64'd0;
    fwd_addr_0 = 5'd0; fwd_addr_1 = 5'd0;
    #3;
    chk("rst_we", we, 0);
    chk("rst_alu_ready", alu_ready, 0);
    chk("rst_lsu_ready", lsu_ready, 0);
    chk("rst_wr_addr", wr_addr, 0);
    alu_valid = 1'b0; lsu_valid = 1'b0;
    #9 rst = 1'b1;
    tick();

    // single ALU result, one-cycle latency
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'h1234; #1;
    chk("t1_ready", alu_ready, 1);
    chk("t1_we_pre", we, 0);
    tick();
    alu_valid = 1'b0; #1;
    chk("t1_we", we, 1);
    chk("t1_addr", wr_addr, 5);
    chk("t1_data", wr_data, 64'h1234);
    tick();
    chk("t1_we_after", we, 0);

    // round robin with both sources valid
    alu_valid = 1'b1; lsu_valid = 1'b1; alu_rd = 5'd1; lsu_rd = 5'd2;
    alu_data = 64'h11; lsu_data = 64'h22; #1;
    chk("rr_a_alu_ready", alu_ready, 1);
    chk("rr_a_lsu_ready", lsu_ready, 0);
    tick();
    chk("rr_b_alu_ready", alu_ready, 0);
    chk("rr_b_lsu_ready", lsu_ready, 1);
    chk("rr_b_addr", wr_addr, 1);
    tick();
    chk("rr_c_alu_ready", alu_ready, 1);
    chk("rr_c_addr", wr_addr, 2);
    chk("rr_c_data", wr_data, 64'h22);
    tick();
    chk("rr_d_lsu_ready", lsu_ready, 1);
    chk("rr_d_addr", wr_addr, 1);
    tick();
    alu_valid = 1'b0; lsu_valid = 1'b0; #1;
    chk("rr_e_addr", wr_addr, 2);
    tick();
    chk("rr_we_after", we, 0);

    // fill under stall, then drain in order
    wr_stall = 1'b1;
    alu_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      alu_rd = 5'(i); alu_data = 64'h100 + 64'(i); #1;
      chk("fill_ready", alu_ready, 1);
      chk("fill_we_stalled", we, 0);
      tick();
    end
    alu_rd = 5'd5; alu_data = 64'h105; #1;
    chk("full_alu_ready", alu_ready, 0);
    chk("full_lsu_ready", lsu_ready, 0);
    tick();
    chk("full_hold_ready", alu_ready, 0);
    wr_stall = 1'b0; #1;
    chk("drain1_addr", wr_addr, 1);
    chk("drain1_ready_same_cycle_pop", alu_ready, 0);
    tick();
    chk("drain2_addr", wr_addr, 2);
    chk("drain2_ready", alu_ready, 1);
    tick();
    alu_valid = 1'b0; #1;
    chk("drain3_addr", wr_addr, 3);
    tick();
    chk("drain4_addr", wr_addr, 4);
    chk("drain4_data", wr_data, 64'h104);
    tick();
    chk("drain5_addr", wr_addr, 5);
    chk("drain5_data", wr_data, 64'h105);
    tick();
    chk("drain_we_after", we, 0);

    // rd=0 is accepted but discarded
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'hFF; #1;
    chk("rd0_ready", alu_ready, 1);
    tick();
    alu_valid = 1'b0; #1;
    chk("rd0_we", we, 0);
    tick();
    chk("rd0_we_later", we, 0);

    // forwarding lookup under stall
    wr_stall = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 64'hA;
    tick();
    alu_data = 64'hB;
    tick();
    alu_valid = 1'b0; fwd_addr_0 = 5'd7; fwd_addr_1 = 5'd0; #1;
`ifdef WRITEBACK_QUEUE_FWD_EN
    chk("fwd0_hit", fwd_hit_0, 1);
    chk("fwd0_data", fwd_data_0, 64'hB);
`else
    chk("fwd0_hit_off", fwd_hit_0, 0);
    chk("fwd0_data_off", fwd_data_0, 0);
`endif
    chk("fwd1_hit_zero", fwd_hit_1, 0);
    chk("fwd1_data_zero", fwd_data_1, 0);

    // third entry, then reset mid-cycle
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 64'h99;
    tick();
    wr_stall = 1'b0; #1;
    chk("pre_rst_we", we, 1);
    chk("pre_rst_addr", wr_addr, 7);
    chk("pre_rst_data", wr_data, 64'hA);
    #1 rst = 1'b0; #1;
    chk("mid_rst_we", we, 0);
    chk("mid_rst_alu_ready", alu_ready, 0);
    chk("mid_rst_lsu_ready", lsu_ready, 0);
    chk("mid_rst_wr_data", wr_data, 0);
    chk("mid_rst_fwd_hit", fwd_hit_0, 0);
    tick();
    alu_valid = 1'b0; #2 rst = 1'b1;
    tick();
    chk("post_rst_we_1", we, 0);
    tick();
    chk("post_rst_we_2", we, 0);
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 64'h33; #1;
    chk("post_rst_ready", alu_ready, 1);
    tick();
    alu_valid = 1'b0; #1;
    chk("post_rst_new_we", we, 1);
    chk("post_rst_new_addr", wr_addr, 3);
    tick();
    chk("post_rst_we_end", we, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
